// File: rtl/data_mem_pipe.sv
// -----------------------------------------------------------------------------
// data_mem_pipe
//
// Single-port, byte-writable data memory with a fixed-latency, in-order response
// path and a credit-style request grant.
//
// Every accepted request (read or write) produces exactly one response, in
// acceptance order. A response appears on rvalid READ_LATENCY cycles after the
// cycle in which the request was accepted. If it cannot be consumed yet, it
// waits in a small response buffer behind older responses. An occupancy counter
// covers both the latency pipeline and the buffer. A request is granted only
// while a free response slot is guaranteed, so the pipeline never stalls and
// the buffer never overflows.
//
// Parameters
//   DATA_WIDTH   word width in bits (multiple of 8)
//   ADDR_WIDTH   word-address width
//   MEM_WORDS    implemented words, 1 .. 2**ADDR_WIDTH
//   READ_LATENCY accept-to-response cycles, 1 .. 4
//   RESP_DEPTH   maximum accepted-but-unconsumed responses, >= 1
//
// Ports
//   clk     in   clock, all state updates on the rising edge
//   rst     in   asynchronous, active-high reset
//   req     in   request valid
//   gnt     out  request slot available; a request is accepted when req && gnt
//   we      in   1 = write, 0 = read
//   be      in   byte enables, bit i covers wdata[8i+7:8i]
//   addr    in   word address
//   wdata   in   write data
//   rvalid  out  response valid
//   rready  in   response consumed when rvalid && rready
//   rdata   out  read data (0 for write and error responses)
//   rerr    out  response error flag (address >= MEM_WORDS)
// -----------------------------------------------------------------------------
module data_mem_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 1,
    parameter int RESP_DEPTH   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    output logic                    gnt,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    rvalid,
    input  logic                    rready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rerr
);

    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
    // The response buffer itself is the last latency stage, so only
    // READ_LATENCY-1 registers sit in front of it.
    localparam int STAGES = READ_LATENCY - 1;

    typedef struct packed {
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } resp_t;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    logic                  accept;
    logic                  in_range;
    logic [IDX_W-1:0]      mem_idx;
    resp_t                 acc_resp;

    logic                  push;
    resp_t                 push_resp;
    logic                  pop;

    resp_t                 fifo_q [RESP_DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      occ_q, occ_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // Request front end
    // -------------------------------------------------------------------------
    // The grant looks only at registered occupancy: a pop in the same cycle
    // does not open a slot until the next cycle, which keeps gnt free of any
    // combinational path from rready.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path (defaults
        // first), otherwise synthesis infers a latch.
        acc_resp      = '0;
        gnt           = !rst && (occ_q < CNT_W'(RESP_DEPTH));
        accept        = req && gnt;
        // One extra bit so MEM_WORDS == 2**ADDR_WIDTH is representable.
        in_range      = ({1'b0, addr} < (ADDR_WIDTH + 1)'(MEM_WORDS));
        mem_idx       = addr[IDX_W-1:0];
        acc_resp.err  = !in_range;
        // The read samples the array before this edge's write, so it sees
        // every write accepted in earlier cycles.
        if (accept && !we && in_range) begin
            acc_resp.data = mem_q[mem_idx];
        end
    end

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    // NOTE: storage arrays take no reset; clearing them would need a port per
    // word or a multi-cycle sweep, and the contents are defined by writes.
    always_ff @(posedge clk) begin
        if (accept && we && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Latency pipeline (never stalls: occupancy guarantees a buffer slot)
    // -------------------------------------------------------------------------
    if (STAGES > 0) begin : gen_pipe
        logic [STAGES-1:0] pv_q, pv_d;
        resp_t             pr_q [STAGES];
        resp_t             pr_d [STAGES];

        always_comb begin
            pv_d[0] = accept;
            pr_d[0] = acc_resp;
            for (int i = 1; i < STAGES; i++) begin
                pv_d[i] = pv_q[i-1];
                pr_d[i] = pr_q[i-1];
            end
        end

        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pv_q <= '0;
                for (int i = 0; i < STAGES; i++) begin
                    pr_q[i] <= '0;
                end
            end else begin
                pv_q <= pv_d;
                pr_q <= pr_d;
            end
        end

        assign push      = pv_q[STAGES-1];
        assign push_resp = pr_q[STAGES-1];
    end else begin : gen_no_pipe
        assign push      = accept;
        assign push_resp = acc_resp;
    end

    // -------------------------------------------------------------------------
    // Response buffer and occupancy
    // -------------------------------------------------------------------------
    always_comb begin
        rvalid = (cnt_q != '0);
        pop    = rvalid && rready;
        // Gated by rvalid so an empty buffer (and reset) reads as zero.
        rdata  = rvalid ? fifo_q[head_q].data : '0;
        rerr   = rvalid && fifo_q[head_q].err;

        head_d = pop  ? ptr_inc(head_q) : head_q;
        tail_d = push ? ptr_inc(tail_q) : tail_q;

        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        occ_d = occ_q;
        case ({accept, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Asynchronous reset empties the pipeline and buffer at once, discarding
    // every in-flight response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[tail_q] <= push_resp;
        end
    end

endmodule

// File: tb/tb_data_mem_pipe.sv
// -----------------------------------------------------------------------------
// tb_data_mem_pipe
//
// Directed bench for data_mem_pipe using two instances:
//   dut_a  READ_LATENCY=1, RESP_DEPTH=2, MEM_WORDS=1000 (write/read, byte
//          enables, out-of-range, backpressure)
//   dut_b  READ_LATENCY=3, RESP_DEPTH=4 (streaming reads, reset mid-flight)
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_data_mem_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        a_req, a_gnt, a_we, a_rvalid, a_rready, a_rerr;
    logic [3:0]  a_be;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;

    logic        b_req, b_gnt, b_we, b_rvalid, b_rready, b_rerr;
    logic [3:0]  b_be;
    logic [9:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    data_mem_pipe #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .MEM_WORDS(1000),
        .READ_LATENCY(1), .RESP_DEPTH(2)
    ) dut_a (
        .clk(clk), .rst(rst), .req(a_req), .gnt(a_gnt), .we(a_we), .be(a_be),
        .addr(a_addr), .wdata(a_wdata), .rvalid(a_rvalid), .rready(a_rready),
        .rdata(a_rdata), .rerr(a_rerr)
    );

    data_mem_pipe #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10), .MEM_WORDS(1024),
        .READ_LATENCY(3), .RESP_DEPTH(4)
    ) dut_b (
        .clk(clk), .rst(rst), .req(b_req), .gnt(b_gnt), .we(b_we), .be(b_be),
        .addr(b_addr), .wdata(b_wdata), .rvalid(b_rvalid), .rready(b_rready),
        .rdata(b_rdata), .rerr(b_rerr)
    );

    // Word written to dut_b address i.
    function automatic logic [31:0] exp_b(input int i);
        return 32'h0B00_0000 + 32'(i) * 32'h0000_1111;
    endfunction

    task automatic drive_a(input logic r, input logic w, input logic [3:0] b,
                           input logic [9:0] ad, input logic [31:0] d);
        a_req = r; a_we = w; a_be = b; a_addr = ad; a_wdata = d;
    endtask

    task automatic drive_b(input logic r, input logic w, input logic [3:0] b,
                           input logic [9:0] ad, input logic [31:0] d);
        b_req = r; b_we = w; b_be = b; b_addr = ad; b_wdata = d;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({a_gnt, a_rvalid, a_rerr, a_rdata} !== 35'h0)
            $display("FAIL reset_a: got gnt/rvalid/rerr/rdata %h expected 0", {a_gnt, a_rvalid, a_rerr, a_rdata});
        else n_pass++;
        n_checks++;
        if ({b_gnt, b_rvalid, b_rerr, b_rdata} !== 35'h0)
            $display("FAIL reset_b: got gnt/rvalid/rerr/rdata %h expected 0", {b_gnt, b_rvalid, b_rerr, b_rdata});
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (a_gnt !== 1'b1) $display("FAIL gnt_after_reset_a: got %b expected 1", a_gnt);
        else n_pass++;
        n_checks++;
        if (b_gnt !== 1'b1) $display("FAIL gnt_after_reset_b: got %b expected 1", b_gnt);
        else n_pass++;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_write_read();
        @(negedge clk);
        a_rready = 1'b1;
        drive_a(1'b1, 1'b1, 4'hF, 10'd5, 32'hDEADBEEF);
        n_checks++;
        if (a_gnt !== 1'b1) $display("FAIL wr5_gnt: got %b expected 1", a_gnt);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({a_rvalid, a_rerr, a_rdata} !== {2'b10, 32'h0})
            $display("FAIL wr5_resp: got %h expected %h", {a_rvalid, a_rerr, a_rdata}, {2'b10, 32'h0});
        else n_pass++;
        drive_a(1'b1, 1'b0, 4'h0, 10'd5, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({a_rvalid, a_rerr, a_rdata} !== {2'b10, 32'hDEADBEEF})
            $display("FAIL rd5_resp: got %h expected %h", {a_rvalid, a_rerr, a_rdata}, {2'b10, 32'hDEADBEEF});
        else n_pass++;
        drive_a(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (a_rvalid !== 1'b0) $display("FAIL rd5_idle: got rvalid %b expected 0", a_rvalid);
        else n_pass++;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_byte_enable();
        @(negedge clk);
        drive_a(1'b1, 1'b1, 4'b0101, 10'd5, 32'h11223344);
        @(negedge clk);
        n_checks++;
        if ({a_rvalid, a_rerr, a_rdata} !== {2'b10, 32'h0})
            $display("FAIL be0101_resp: got %h expected %h", {a_rvalid, a_rerr, a_rdata}, {2'b10, 32'h0});
        else n_pass++;
        drive_a(1'b1, 1'b1, 4'b0000, 10'd5, 32'hFFFFFFFF);
        @(negedge clk);
        n_checks++;
        if ({a_rvalid, a_rerr, a_rdata} !== {2'b10, 32'h0})
            $display("FAIL be0000_resp: got %h expected %h", {a_rvalid, a_rerr, a_rdata}, {2'b10, 32'h0});
        else n_pass++;
        drive_a(1'b1, 1'b0, 4'h0, 10'd5, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({a_rvalid, a_rerr, a_rdata} !== {2'b10, 32'hDE22BE44})
            $display("FAIL be_merge: got %h expected %h", {a_rvalid, a_rerr, a_rdata}, {2'b10, 32'hDE22BE44});
        else n_pass++;
        drive_a(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (a_rvalid !== 1'b0) $display("FAIL be_idle: got rvalid %b expected 0", a_rvalid);
        else n_pass++;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_out_of_range();
        @(negedge clk);
        drive_a(1'b1, 1'b1, 4'hF, 10'd999, 32'hCAFEF00D);
        @(negedge clk);
        n_checks++;
        if ({a_rvalid, a_rerr, a_rdata} !== {2'b10, 32'h0})
            $display("FAIL wr999_resp: got %h expected %h", {a_rvalid, a_rerr, a_rdata}, {2'b10, 32'h0});
        else n_pass++;
        drive_a(1'b1, 1'b1, 4'hF, 10'd1000, 32'h12345678);
        @(negedge clk);
        n_checks++;
        if ({a_rvalid, a_rerr, a_rdata} !== {2'b11, 32'h0})
            $display("FAIL wr1000_resp: got %h expected %h", {a_rvalid, a_rerr, a_rdata}, {2'b11, 32'h0});
        else n_pass++;
        drive_a(1'b1, 1'b0, 4'h0, 10'd1000, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({a_rvalid, a_rerr, a_rdata} !== {2'b11, 32'h0})
            $display("FAIL rd1000_resp: got %h expected %h", {a_rvalid, a_rerr, a_rdata}, {2'b11, 32'h0});
        else n_pass++;
        drive_a(1'b1, 1'b0, 4'h0, 10'd999, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({a_rvalid, a_rerr, a_rdata} !== {2'b10, 32'hCAFEF00D})
            $display("FAIL rd999_resp: got %h expected %h", {a_rvalid, a_rerr, a_rdata}, {2'b10, 32'hCAFEF00D});
        else n_pass++;
        drive_a(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_backpressure();
        int accepts = 0;
        @(negedge clk);
        a_rready = 1'b0;
        drive_a(1'b1, 1'b0, 4'h0, 10'd5, 32'h0);
        if (a_req && a_gnt) accepts++;
        @(negedge clk);
        drive_a(1'b1, 1'b0, 4'h0, 10'd999, 32'h0);
        if (a_req && a_gnt) accepts++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive_a(1'b1, 1'b0, 4'h0, 10'd0, 32'h0);
            if (a_req && a_gnt) accepts++;
            n_checks++;
            if (a_gnt !== 1'b0) $display("FAIL bp_gnt_low[%0d]: got %b expected 0", k, a_gnt);
            else n_pass++;
            n_checks++;
            if ({a_rvalid, a_rerr, a_rdata} !== {2'b10, 32'hDE22BE44})
                $display("FAIL bp_hold[%0d]: got %h expected %h", k, {a_rvalid, a_rerr, a_rdata}, {2'b10, 32'hDE22BE44});
            else n_pass++;
        end
        n_checks++;
        if (accepts !== 2) $display("FAIL bp_accepts: got %0d expected 2", accepts);
        else n_pass++;
        a_rready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_gnt !== 1'b1) $display("FAIL bp_gnt_return: got %b expected 1", a_gnt);
        else n_pass++;
        n_checks++;
        if ({a_rvalid, a_rerr, a_rdata} !== {2'b10, 32'hCAFEF00D})
            $display("FAIL bp_second: got %h expected %h", {a_rvalid, a_rerr, a_rdata}, {2'b10, 32'hCAFEF00D});
        else n_pass++;
        drive_a(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (a_rvalid !== 1'b0) $display("FAIL bp_drained: got rvalid %b expected 0", a_rvalid);
        else n_pass++;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_fill_b();
        int gnt_miss = 0;
        int n_resp   = 0;
        int bad_resp = 0;
        b_rready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c < 8) drive_b(1'b1, 1'b1, 4'hF, 10'(c), exp_b(c));
            else       drive_b(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
            if (b_req && !b_gnt) gnt_miss++;
            if (b_rvalid) begin
                n_resp++;
                if ({b_rerr, b_rdata} !== 33'h0) bad_resp++;
            end
        end
        n_checks++;
        if (gnt_miss !== 0) $display("FAIL fill_gnt: got %0d stalls expected 0", gnt_miss);
        else n_pass++;
        n_checks++;
        if (n_resp !== 8) $display("FAIL fill_resp_count: got %0d expected 8", n_resp);
        else n_pass++;
        n_checks++;
        if (bad_resp !== 0) $display("FAIL fill_resp_value: got %0d nonzero expected 0", bad_resp);
        else n_pass++;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_back_to_back();
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (c >= 3 && c <= 10) begin
                n_checks++;
                if ({b_rvalid, b_rerr, b_rdata} !== {2'b10, exp_b(c - 3)})
                    $display("FAIL b2b_resp[%0d]: got %h expected %h", c, {b_rvalid, b_rerr, b_rdata}, {2'b10, exp_b(c - 3)});
                else n_pass++;
            end else begin
                n_checks++;
                if (b_rvalid !== 1'b0) $display("FAIL b2b_gap[%0d]: got rvalid %b expected 0", c, b_rvalid);
                else n_pass++;
            end
            if (c < 8) begin
                drive_b(1'b1, 1'b0, 4'h0, 10'(c), 32'h0);
                n_checks++;
                if (b_gnt !== 1'b1) $display("FAIL b2b_gnt[%0d]: got %b expected 1", c, b_gnt);
                else n_pass++;
            end else begin
                drive_b(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset_midflight();
        int stale = 0;
        @(negedge clk);
        drive_b(1'b1, 1'b0, 4'h0, 10'd1, 32'h0);
        @(negedge clk);
        drive_b(1'b1, 1'b0, 4'h0, 10'd2, 32'h0);
        @(negedge clk);
        drive_b(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({b_rvalid, b_rerr, b_rdata} !== {2'b10, exp_b(1)})
            $display("FAIL mid_before_rst: got %h expected %h", {b_rvalid, b_rerr, b_rdata}, {2'b10, exp_b(1)});
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({b_gnt, b_rvalid, b_rerr, b_rdata} !== 35'h0)
            $display("FAIL mid_async_clear: got gnt/rvalid/rerr/rdata %h expected 0", {b_gnt, b_rvalid, b_rerr, b_rdata});
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (b_gnt !== 1'b1) $display("FAIL mid_gnt_release: got %b expected 1", b_gnt);
        else n_pass++;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (b_rvalid !== 1'b0) stale++;
        end
        n_checks++;
        if (stale !== 0) $display("FAIL mid_stale: got %0d stale cycles expected 0", stale);
        else n_pass++;
        drive_b(1'b1, 1'b0, 4'h0, 10'd7, 32'h0);
        @(negedge clk);
        drive_b(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({b_rvalid, b_rerr, b_rdata} !== {2'b10, exp_b(7)})
            $display("FAIL mid_recover: got %h expected %h", {b_rvalid, b_rerr, b_rdata}, {2'b10, exp_b(7)});
        else n_pass++;
    endtask

    // -------------------------------------------------------------------------
    initial begin
        drive_a(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        drive_b(1'b0, 1'b0, 4'h0, 10'd0, 32'h0);
        a_rready = 1'b0;
        b_rready = 1'b0;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_out_of_range();
        test_backpressure();
        test_fill_b();
        test_back_to_back();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_mem_pipe.md
DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 10, word-address width.
REQ-003 Parameter MEM_WORDS, default 1024, implemented words; SHALL satisfy 1 <= MEM_WORDS <= 2**ADDR_WIDTH.
REQ-004 Parameter READ_LATENCY, default 1, accept-to-response cycles; legal range 1..4.
REQ-005 Parameter RESP_DEPTH, default 2, maximum accepted-but-unconsumed responses; SHALL be >= 1.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 req  input  1  request valid.
REQ-009 gnt  output  1  request accepted this cycle when req && gnt.
REQ-010 we  input  1  1 = write, 0 = read.
REQ-011 be  input  DATA_WIDTH/8  byte enables, bit i covers wdata[8i+7:8i].
REQ-012 addr  input  ADDR_WIDTH  word address.
REQ-013 wdata  input  DATA_WIDTH  write data.
REQ-014 rvalid  output  1  response valid.
REQ-015 rready  input  1  response consumed when rvalid && rready.
REQ-016 rdata  output  DATA_WIDTH  read data; 0 for write and error responses.
REQ-017 rerr  output  1  response error flag (address >= MEM_WORDS).

Function
REQ-018 Every accepted request (read or write) SHALL produce exactly one response, in acceptance order.
REQ-019 Occupancy counter SHALL track accepted-but-unconsumed responses (pipeline stages plus response buffer), range 0..RESP_DEPTH.
REQ-020 gnt SHALL be 1 iff occupancy < RESP_DEPTH, independent of req and of a same-cycle pop.
REQ-021 Accept and pop in the same cycle SHALL leave occupancy unchanged; accept only +1; pop only -1.
REQ-022 Accepted write with addr < MEM_WORDS SHALL update exactly the bytes with be[i]=1 at that clock edge; be all-zero writes nothing but still responds.
REQ-023 Accepted read with addr < MEM_WORDS SHALL sample the memory word at the accept edge, reflecting all writes accepted in earlier cycles.
REQ-024 Accepted request with addr >= MEM_WORDS SHALL not modify memory and SHALL respond with rerr=1, rdata=0.
REQ-025 A response SHALL first present rvalid=1 exactly READ_LATENCY cycles after its accept edge when no older response is stalled; otherwise it waits in order behind older ones.
REQ-026 While rvalid=1 and rready=0, rvalid, rdata and rerr SHALL hold stable.
REQ-027 Back-to-back accepts with rready held 1 SHALL sustain one response per cycle when RESP_DEPTH >= READ_LATENCY+1.
REQ-028 Request inputs SHALL be ignored in cycles where gnt=0 or req=0.
REQ-029 Memory array contents SHALL not be reset and power up undefined; bench initialises before reading.

Reset
REQ-030 While rst=1: gnt=0, rvalid=0, rerr=0, rdata=0, occupancy=0, all pipeline stages empty, no memory write.
REQ-031 Assertion of rst mid-operation SHALL discard all in-flight and buffered responses immediately (asynchronously).
REQ-032 First request SHALL be accepted in the first cycle after rst deasserts (gnt=1).

Verification
REQ-033 Write addr 5, be=1111, wdata 0xDEADBEEF; next cycle read addr 5 -> write response rdata=0 rerr=0, then read response 0xDEADBEEF after READ_LATENCY.
REQ-034 Write addr 5, be=0101, wdata 0x11223344 over 0xDEADBEEF; read 5 -> 0xDE22BE44.
REQ-035 MEM_WORDS=1000, write then read addr 1000 -> both responses rerr=1, rdata=0; addr 999 content unchanged.
REQ-036 RESP_DEPTH=2, rready=0, req held 1 -> exactly 2 accepts, gnt=0 thereafter, rvalid/rdata stable; raise rready -> responses drain in order, gnt returns 1 the cycle after first pop.
REQ-037 READ_LATENCY=3, RESP_DEPTH=4, 8 back-to-back reads addr 0..7, rready=1 -> 8 consecutive rvalid cycles starting 3 cycles after first accept, data in address order.
REQ-038 Assert rst with 2 reads in flight -> rvalid=0 immediately, no stale response after release, gnt=1 first cycle after release.
